mcs8_bus_resp: RTL

//  Bus responder for the MCS8 CPU: the memory/IO side of the 8008 bus.

---
 rtl/mcs8_bus_resp.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mcs8_bus_resp.sv
// Memory/IO responder on the 8008 bus: latches the T1/T2 address, runs the
// memory or IO transfer, paces the CPU with READY and jams a vector on T1I.
module mcs8_bus_resp #(
  parameter int         TIMEOUT = 64,
  parameter logic [7:0] INT_VEC = 8'h05
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        SYNC_I,
  input  logic [2:0]  STATE_I,
  input  logic [7:0]  CPU_DAT_I,
  output logic [7:0]  CPU_DAT_O,
  output logic        CPU_OE_O,
  output logic        READY_O,
  output logic [13:0] MEM_ADDR_O,
  output logic        MEM_REQ_O,
  output logic        MEM_WE_O,
  output logic [7:0]  MEM_WDAT_O,
  input  logic [7:0]  MEM_RDAT_I,
  input  logic        MEM_ACK_I,
  output logic [4:0]  IO_PORT_O,
  output logic        IO_RD_O,
  output logic        IO_WR_O,
  output logic [7:0]  IO_WDAT_O,
  input  logic [7:0]  IO_RDAT_I,
  input  logic [7:0]  INT_VEC_I,
  input  logic        INT_VEC_EN_I,
  output logic        INT_ACK_O,
  output logic        HALT_O,
  output logic        BUS_ERR_O
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADRL, S_RDWAIT, S_IORD, S_WCAP, S_WPEND, S_DRIVE, S_DONE
  } state_t;

  localparam logic [2:0] ST_T1   = 3'b010;
  localparam logic [2:0] ST_T2   = 3'b100;
  localparam logic [2:0] ST_T3   = 3'b001;
  localparam logic [2:0] ST_T1I  = 3'b110;
  localparam logic [2:0] ST_STOP = 3'b011;
  localparam logic [2:0] ST_WAIT = 3'b000;
  localparam int         TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            sync_q;
  logic [13:0]     addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [1:0]      cyc_q, cyc_d;
  logic            int_ack_q, int_ack_d, halt_q, halt_d;
  logic            ready_q, ready_d, oe_q, oe_d;
  logic [7:0]      rdata_q, rdata_d, wdat_q, wdat_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic            io_rd_q, io_rd_d, io_wr_q, io_wr_d;
  logic            bus_err_q, bus_err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tick, dispatch, dinp, timeout;
  logic [1:0]      dcyc;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cyc_d      = cyc_q;
    int_ack_d  = int_ack_q;
    halt_d     = halt_q;
    ready_d    = ready_q;
    oe_d       = oe_q;
    rdata_d    = rdata_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    wdat_d     = wdat_q;
    timer_d    = timer_q;
    bus_err_d  = bus_err_q;
    io_rd_d    = 1'b0;
    io_wr_d    = 1'b0;
    tick       = sync_q & ~SYNC_I;
    dispatch   = 1'b0;
    dcyc       = cyc_q;
    dinp       = (addr_q[13:12] == 2'b00);
    timeout    = mem_req_q && !MEM_ACK_I && (timer_q == TLAST);

    // Request lifetime runs independently of the FSM so posted writes can complete.
    if (mem_req_q) begin
      timer_d = timer_q + TW'(1);
      if (MEM_ACK_I || timeout) mem_req_d = 1'b0;
      if (timeout) bus_err_d = 1'b1;
    end
    if (tick) halt_d = (STATE_I == ST_STOP);

    case (state_q)
      S_ADRL: if (tick && STATE_I == ST_T2) begin
        addr_d[13:8] = CPU_DAT_I[5:0];
        cyc_d        = CPU_DAT_I[7:6];
        dcyc         = CPU_DAT_I[7:6];
        dinp         = (CPU_DAT_I[5:4] == 2'b00);
        if (mem_req_q) begin
          ready_d = 1'b0;
          state_d = S_WPEND;
        end else begin
          dispatch = 1'b1;
        end
      end
      S_WPEND: if (!mem_req_q) dispatch = 1'b1;
      S_RDWAIT: if (mem_req_q && (MEM_ACK_I || timeout)) begin
        rdata_d = MEM_ACK_I ? MEM_RDAT_I : 8'hFF;
        ready_d = 1'b1;
        oe_d    = 1'b1;
        state_d = S_DRIVE;
      end
      S_IORD: begin
        rdata_d = IO_RDAT_I;
        oe_d    = 1'b1;
        state_d = S_DRIVE;
      end
      S_WCAP: if (tick && STATE_I == ST_T3) begin
        wdat_d     = CPU_DAT_I;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = addr_q;
        timer_d    = '0;
        state_d    = S_DONE;
      end
      S_DRIVE: if (tick && STATE_I != ST_T3 && STATE_I != ST_WAIT) begin
        oe_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        int_ack_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: ;
    endcase

    if (dispatch) begin
      ready_d = 1'b1;
      if (!dcyc[0]) begin
        if (int_ack_q) begin
          rdata_d = INT_VEC_EN_I ? INT_VEC_I : INT_VEC;
          oe_d    = 1'b1;
          state_d = S_DRIVE;
        end else begin
          ready_d    = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_d;
          timer_d    = '0;
          state_d    = S_RDWAIT;
        end
      end else if (!dcyc[1]) begin
        if (dinp) begin
          io_rd_d = 1'b1;
          state_d = S_IORD;
        end else begin
          io_wr_d = 1'b1;
          state_d = S_DONE;
        end
      end else begin
        state_d = S_WCAP;
      end
    end

    // A new T1/T1I always starts a fresh cycle; STOP parks the FSM.
    if (tick && (STATE_I == ST_T1 || STATE_I == ST_T1I)) begin
      addr_d[7:0] = CPU_DAT_I;
      int_ack_d   = (STATE_I == ST_T1I);
      oe_d        = 1'b0;
      ready_d     = 1'b1;
      state_d     = S_ADRL;
    end else if (tick && STATE_I == ST_STOP) begin
      oe_d    = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= S_IDLE;
      sync_q     <= 1'b0;
      addr_q     <= '0;
      cyc_q      <= '0;
      int_ack_q  <= 1'b0;
      halt_q     <= 1'b0;
      ready_q    <= 1'b1;
      oe_q       <= 1'b0;
      rdata_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wdat_q     <= '0;
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= SYNC_I;
      addr_q     <= addr_d;
      cyc_q      <= cyc_d;
      int_ack_q  <= int_ack_d;
      halt_q     <= halt_d;
      ready_q    <= ready_d;
      oe_q       <= oe_d;
      rdata_q    <= rdata_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      wdat_q     <= wdat_d;
      io_rd_q    <= io_rd_d;
      io_wr_q    <= io_wr_d;
      bus_err_q  <= bus_err_d;
      timer_q    <= timer_d;
    end
  end

  assign CPU_DAT_O  = rdata_q;
  assign CPU_OE_O   = oe_q;
  assign READY_O    = ready_q;
  assign MEM_ADDR_O = mem_addr_q;
  assign MEM_REQ_O  = mem_req_q;
  assign MEM_WE_O   = mem_we_q;
  assign MEM_WDAT_O = wdat_q;
  assign IO_PORT_O  = addr_q[13:9];
  assign IO_RD_O    = io_rd_q;
  assign IO_WR_O    = io_wr_q;
  assign IO_WDAT_O  = addr_q[7:0];
  assign INT_ACK_O  = int_ack_q;
  assign HALT_O     = halt_q;
  assign BUS_ERR_O  = bus_err_q;
endmodule
